// File: rtl/osc_freq_meter_if.sv
// Control/result bundle for osc_freq_meter.
//   master (requester) : drives start, cont, gate_len, ch_sel; reads results
//   slave  (meter)     : reads the controls; drives count_out, ovf, busy, done
//   start     level-sampled measurement request
//   cont      continuous re-arm after every window
//   gate_len  window length in clk cycles (0 = 2^GATE_W)
//   ch_sel    result channel shown on count_out
//   count_out result of channel ch_sel (0 when out of range)
//   ovf       per-channel saturation flags of the last completed window
//   busy      measurement in progress
//   done      one-cycle pulse, new results visible
interface osc_freq_meter_if #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
);
    logic              start;
    logic              cont;
    logic [GATE_W-1:0] gate_len;
    logic [CH_W-1:0]   ch_sel;
    logic [CNT_W-1:0]  count_out;
    logic [NCH-1:0]    ovf;
    logic              busy;
    logic              done;

    modport master (
        output start, cont, gate_len, ch_sel,
        input  count_out, ovf, busy, done
    );

    modport slave (
        input  start, cont, gate_len, ch_sel,
        output count_out, ovf, busy, done
    );
endinterface

// File: rtl/osc_freq_meter.sv
// Multi-channel oscillator frequency meter: counts rising edges of each
// asynchronous osc_in bit over a programmable gate window of clk cycles.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   ena    block enable; low returns to IDLE and clears the counters
//   osc_in asynchronous oscillator inputs, one per channel
//   bus    control/result bundle (slave side), see osc_freq_meter_if
module osc_freq_meter #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [NCH-1:0] osc_in,
    osc_freq_meter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

    state_t            state;
    logic [NCH-1:0]    sync1, sync2, hist, rise;
    logic [GATE_W-1:0] timer;
    logic [CNT_W-1:0]  cnt [NCH];
    logic [CNT_W-1:0]  res [NCH];
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    ovf_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  count_mux;

    // Two-flop synchroniser plus history flop per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            pend   <= '0;
            ovf_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                res[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            if (!ena) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                pend   <= '0;
                for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start || bus.cont) begin
                            state  <= ARM;
                            busy_r <= 1'b1;
                        end
                    end
                    ARM: begin
                        pend <= '0;
                        for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
                        // Timer holds remaining GATE cycles minus one; the
                        // wrap of 0-1 gives the 2^GATE_W window for gate_len=0.
                        timer <= bus.gate_len - 1'b1;
                        state <= GATE;
                    end
                    GATE: begin
                        for (int unsigned i = 0; i < NCH; i++) begin
                            if (rise[i]) begin
                                if (cnt[i] == '1) pend[i] <= 1'b1;
                                else              cnt[i]  <= cnt[i] + 1'b1;
                            end
                        end
                        timer <= timer - 1'b1;
                        if (timer == '0) state <= LATCH;
                    end
                    LATCH: begin
                        for (int unsigned i = 0; i < NCH; i++) res[i] <= cnt[i];
                        ovf_r  <= pend;
                        done_r <= 1'b1;
                        if (bus.cont) begin
                            state <= ARM;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        count_mux = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(bus.ch_sel) == i) count_mux = res[i];
        end
    end

    assign bus.count_out = count_mux;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed self-checking bench for osc_freq_meter. Two instances share the
// stimulus: dut_a (CNT_W=16) and dut_b (CNT_W=4, used for saturation).
module tb_osc_freq_meter;

    localparam int BIG = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        cont;
    logic [15:0] gate_len;
    logic [1:0]  ch_sel;
    logic [3:0]  osc = '0;

    int checks   = 0;
    int failures = 0;

    // Oscillator generator controls: half period (0 = held low) and an
    // absolute limit on the number of rising edges produced.
    int half  [4] = '{default: 0};
    int lim   [4] = '{default: 0};
    int rises [4] = '{default: 0};
    int ph    [4] = '{default: 0};

    always #5 clk = ~clk;

    osc_freq_meter_if #(.NCH(4), .CNT_W(16), .GATE_W(16)) ia ();
    osc_freq_meter_if #(.NCH(4), .CNT_W(4),  .GATE_W(16)) ib ();

    assign ia.start    = start;
    assign ia.cont     = cont;
    assign ia.gate_len = gate_len;
    assign ia.ch_sel   = ch_sel;
    assign ib.start    = start;
    assign ib.cont     = cont;
    assign ib.gate_len = gate_len;
    assign ib.ch_sel   = ch_sel;

    osc_freq_meter #(.NCH(4), .CNT_W(16), .GATE_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .bus(ia.slave)
    );

    osc_freq_meter #(.NCH(4), .CNT_W(4), .GATE_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .bus(ib.slave)
    );

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (half[c] == 0 || (rises[c] >= lim[c] && osc[c] == 1'b0)) begin
                osc[c] = 1'b0;
                ph[c]  = 0;
            end else begin
                ph[c] = ph[c] + 1;
                if (ph[c] >= half[c]) begin
                    ph[c] = 0;
                    if (osc[c] == 1'b0) begin
                        osc[c]   = 1'b1;
                        rises[c] = rises[c] + 1;
                    end else begin
                        osc[c] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Returns the negedge index (1-based) at which dut_a.done is seen, -1 on timeout.
    task automatic wait_done(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (ia.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cyc, output int k);
        k = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (ia.done !== 1'b0) k++;
        end
    endtask

    task automatic read_ch(input int c, output longint va, output longint vb);
        logic [1:0] sel;
        sel    = 2'(c);
        ch_sel = sel;
        #1;
        va = ia.count_out;
        vb = ib.count_out;
    endtask

    initial begin
        int     n;
        int     k;
        longint va;
        longint vb;

        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        gate_len = 16'd100;
        ch_sel   = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_count", ia.count_out, 0);
        chk("rst_ovf",   ia.ovf, 0);
        chk("rst_busy",  ia.busy, 0);
        chk("rst_done",  ia.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 100-cycle window, ch0 period 10.
        half[0] = 5; lim[0] = BIG;
        repeat (4) @(negedge clk);
        gate_len = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("A_busy", ia.busy, 1);
        wait_done(200, n);
        chk("A_latency", n, 102);
        for (int c = 0; c < 4; c++) begin
            read_ch(c, va, vb);
            if (c == 0) chk_rng("A_ch0", va, 9, 11);
            else        chk("A_chN", va, 0);
        end
        chk("A_ovf", ia.ovf, 0);
        chk("A_busy_end", ia.busy, 0);
        @(negedge clk);
        chk("A_done_width", ia.done, 0);
        half[0] = 0;

        // Saturation: ch2 period 4 over 200 cycles.
        repeat (4) @(negedge clk);
        half[2] = 2; lim[2] = BIG;
        repeat (4) @(negedge clk);
        gate_len = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, n);
        chk("B_latency", n, 202);
        chk("B_done_small", ib.done, 1);
        read_ch(2, va, vb);
        chk("B_small_ch2", vb, 15);
        chk_rng("B_big_ch2", va, 49, 51);
        chk("B_small_ovf", ib.ovf, 4'b0100);
        chk("B_big_ovf", ia.ovf, 0);
        half[2] = 0;

        // Continuous mode, 20-cycle windows.
        repeat (4) @(negedge clk);
        half[0] = 5; lim[0] = BIG;
        gate_len = 16'd20; cont = 1'b1;
        @(negedge clk);
        wait_done(60, n);
        chk("C_first", n, 22);
        wait_done(60, n);
        chk("C_period1", n, 22);
        wait_done(60, n);
        chk("C_period2", n, 22);
        repeat (5) @(negedge clk);
        cont = 1'b0;
        wait_done(60, n);
        chk("C_tail", n, 17);
        chk("C_busy_after", ia.busy, 0);
        count_dones(60, k);
        chk("C_no_more", k, 0);
        half[0] = 0;

        // start and gate_len changes during a 50-cycle window are ignored.
        gate_len = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; gate_len = 16'd5;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("D_busy_mid", ia.busy, 1);
        wait_done(100, n);
        chk("D_len", n, 39);
        count_dones(80, k);
        chk("D_single_done", k, 0);
        chk("D_busy_end", ia.busy, 0);

        // Exactly 7 pulses, then reset mid-window.
        ch_sel = 2'd0;
        gate_len = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        half[0] = 5; lim[0] = rises[0] + 7;
        wait_done(300, n);
        chk("E_latency", n, 202);
        read_ch(0, va, vb);
        chk("E_prior", va, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim[0] = rises[0] + 3;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("E_rst_count", ia.count_out, 0);
        chk("E_rst_ovf",   ia.ovf, 0);
        chk("E_rst_busy",  ia.busy, 0);
        chk("E_rst_done",  ia.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(250, k);
        chk("E_no_done", k, 0);
        chk("E_busy_idle", ia.busy, 0);

        // Exactly 9 pulses, then ena dropped mid-window.
        gate_len = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim[0] = rises[0] + 9;
        wait_done(300, n);
        chk("F_latency", n, 202);
        read_ch(0, va, vb);
        chk("F_prior", va, 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lim[0] = rises[0] + 5;
        repeat (40) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("F_busy", ia.busy, 0);
        chk("F_done", ia.done, 0);
        read_ch(0, va, vb);
        chk("F_hold", va, 9);
        chk("F_ovf", ia.ovf, 0);
        count_dones(20, k);
        chk("F_no_done", k, 0);
        ena = 1'b1;
        half[0] = 0;
        repeat (3) @(negedge clk);
        chk("F_idle", ia.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 Parameter NCH, default 4: number of oscillator input channels (1..8).
REQ-002 Parameter CNT_W, default 16: width of each per-channel edge counter and result register.
REQ-003 Parameter GATE_W, default 16: width of the gate-length setting and the gate timer.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  block enable; 0 forces return to IDLE.
REQ-007 osc_in  input  NCH  asynchronous oscillator outputs, one per channel.
REQ-008 start  input  1  request one measurement window; level-sampled in IDLE.
REQ-009 cont  input  1  continuous mode: re-arm automatically after each window.
REQ-010 gate_len  input  GATE_W  window length in clk cycles; 0 encodes 2^GATE_W.
REQ-011 ch_sel  input  clog2(NCH), min 1  selects the result shown on count_out.
REQ-012 count_out  output  CNT_W  result register of channel ch_sel; out-of-range ch_sel gives 0.
REQ-013 ovf  output  NCH  per-channel overflow flag of the last completed window.
REQ-014 busy  output  1  high in ARM, GATE and LATCH.
REQ-015 done  output  1  one-cycle pulse when new results are latched.

Function
REQ-016 Each osc_in bit SHALL pass a 2-flop synchroniser followed by one history flop; a rising edge is detected when the synchronised value is 1 and the history flop is 0.
REQ-017 The FSM SHALL have exactly four states: IDLE, ARM, GATE, LATCH.
REQ-018 IDLE -> ARM when start=1 or cont=1; otherwise stay in IDLE.
REQ-019 ARM (1 cycle): clear all counters and ovf-pending bits; load the gate timer from gate_len (0 -> 2^GATE_W); -> GATE.
REQ-020 GATE: increment a channel counter on every detected edge; decrement the timer each cycle; after exactly N cycles in GATE (N = loaded length) -> LATCH.
REQ-021 Only edges detected in GATE cycles SHALL be counted; edges detected in ARM or LATCH are dropped.
REQ-022 Counters SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets that channel's ovf-pending bit.
REQ-023 LATCH (1 cycle): copy counters to result registers and ovf-pending to ovf; assert done; -> ARM if cont=1, else -> IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-025 gate_len changes during GATE SHALL not affect the running window; gate_len is sampled only in ARM.
REQ-026 cont deasserted during GATE: the current window completes and latches, then IDLE.
REQ-027 ena=0 in any state: next state IDLE, counters cleared, result registers and ovf retained, done not asserted.
REQ-028 count_out and ovf SHALL change only in the LATCH cycle (visible the cycle after), during reset, or when ch_sel changes (count_out only).
REQ-029 Edge-to-count latency from an osc_in transition is 3 clk cycles (2 sync + detect).

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, all synchroniser and history flops 0, counters 0, timer 0, result registers 0, ovf 0, busy 0, done 0.
REQ-031 Reset asserted mid-window SHALL abort without a done pulse; after release the block waits in IDLE for start or cont.

Verification
REQ-032 NCH=4, gate_len=100, start pulse, osc_in[0] square wave period 10 clk -> done after 1+100+1 cycles; result ch0 = 10 (+/-1), ch1..3 = 0, ovf=0.
REQ-033 CNT_W=4, gate_len=200, osc_in[2] period 4 clk -> result ch2 = 15, ovf[2]=1, other ovf bits 0.
REQ-034 cont=1, gate_len=20 held -> done pulses every 22 cycles; drop cont mid-GATE -> exactly one further done, then busy=0.
REQ-035 start re-asserted and gate_len changed to 5 during a 50-cycle GATE -> window still 50 cycles, single done.
REQ-036 rst_n pulsed low for 1 cycle mid-GATE with prior results 7 -> count_out=0, ovf=0, no done, busy=0 until next start.
REQ-037 ena dropped mid-GATE with prior result 9 -> IDLE next cycle, count_out stays 9, no done.
